// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the data port, one transaction at a time.
// Ports: inst_* fetch side, data_* load/store side, bus_* shared bus, *_stall hazard-unit stalls.
module mem_req_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              inst_stall,
  output logic              data_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              bus_wr_q, bus_wr_d;
  logic [1:0]        bus_size_q, bus_size_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              any_req;
  logic              pick_data;
  logic              inst_busy;
  logic              data_busy;

  assign any_req   = inst_req | data_req;
  assign pick_data = data_req & (~inst_req | DATA_FIRST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)     state_d = ADDR;
      ADDR:    if (bus_addr_ok) state_d = DATA;
      DATA:    if (bus_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state_q)
      ADDR: begin
        bus_req      = 1'b1;
        inst_addr_ok = bus_addr_ok & ~grant_q;
        data_addr_ok = bus_addr_ok & grant_q;
      end
      DATA: begin
        inst_data_ok = bus_data_ok & ~grant_q;
        data_data_ok = bus_data_ok & grant_q;
      end
      default: ;
    endcase
  end

  // Transaction fields are captured once at the grant so the bus sees
  // stable values however long it takes to accept the address.
  always_comb begin
    grant_d     = grant_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if (state_q == IDLE && any_req) begin
      grant_d     = pick_data;
      bus_wr_d    = pick_data & data_wr;
      bus_size_d  = pick_data ? data_size : 2'd2;
      bus_addr_d  = pick_data ? data_addr : inst_addr;
      bus_wdata_d = data_wdata;
    end
  end

  // Read data passes through on the completion cycle, then is held.
  assign inst_rdata   = inst_data_ok ? bus_rdata : inst_rdata_q;
  assign data_rdata   = data_data_ok ? bus_rdata : data_rdata_q;
  assign inst_rdata_d = inst_rdata;
  assign data_rdata_d = data_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= 2'd0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      grant_q      <= grant_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  assign inst_busy  = (state_q != IDLE) & ~grant_q;
  assign data_busy  = (state_q != IDLE) & grant_q;
  assign inst_stall = (inst_req | inst_busy) & ~inst_data_ok;
  assign data_stall = (data_req | data_busy) & ~data_data_ok;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: request agents, bus responder, transaction model.
// Ports: drives every DUT input, compares every DUT output each cycle.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        inst_stall, data_stall;
  logic        dreal = 1'b0;
  logic        spur = 1'b0;

  assign bus_data_ok = dreal | spur;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata),
    .inst_stall(inst_stall), .data_stall(data_stall)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic [31:0] iq[$];
  dreq_t       dq[$];
  logic [31:0] rq[$];

  // Fetch agent: holds the request until the address is accepted.
  initial begin
    inst_req  = 1'b0;
    inst_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (iq.size() > 0) begin
        inst_req  = 1'b1;
        inst_addr = iq.pop_front();
        do @(negedge clk); while (!(inst_addr_ok && rst));
        @(posedge clk); #1;
        inst_req = 1'b0;
      end
    end
  end

  // Data agent.
  initial begin
    dreq_t r;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dq.size() > 0) begin
        r = dq.pop_front();
        data_req = 1'b1; data_wr = r.wr; data_size = r.size;
        data_addr = r.addr; data_wdata = r.wdata;
        do @(negedge clk); while (!(data_addr_ok && rst));
        @(posedge clk); #1;
        data_req = 1'b0;
      end
    end
  end

  // Bus responder with programmable wait states.
  int   a_dly = 0;
  int   d_dly = 0;
  int   acnt = 0;
  int   dcnt = 0;
  int   nrd = 0;
  logic in_data = 1'b0;
  initial begin
    logic ta, td, rl;
    bus_addr_ok = 1'b0;
    bus_rdata   = '0;
    forever begin
      @(negedge clk);
      ta = bus_req & bus_addr_ok;
      td = in_data & dreal;
      rl = !rst;
      @(posedge clk); #1;
      if (rl) begin
        in_data = 1'b0; acnt = 0; dcnt = 0;
      end else if (ta) begin
        in_data = 1'b1; acnt = 0; dcnt = 0;
      end else if (td) begin
        in_data = 1'b0; dcnt = 0;
      end
      bus_addr_ok = bus_req && (acnt == a_dly);
      if (bus_req) acnt++;
      dreal = in_data && (dcnt == d_dly);
      if (in_data) dcnt++;
      if (dreal) begin
        bus_rdata = (rq.size() > 0) ? rq.pop_front() : 32'h5A5A0000 + nrd;
        nrd++;
      end
    end
  end

  // Transaction-level model: one pending transaction, address then data.
  typedef struct {
    logic        side;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        m_busy = 1'b0;
  logic        m_acc = 1'b0;
  txn_t        m_t = '{1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
  logic [31:0] m_ir = '0;
  logic [31:0] m_dr = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_acc = 1'b0; m_ir = '0; m_dr = '0;
      m_t = '{1'b0, 1'b0, 2'd0, 32'd0, 32'd0};
    end else if (!m_busy) begin
      if (data_req) begin
        m_busy = 1'b1; m_acc = 1'b0;
        m_t = '{1'b1, data_wr, data_size, data_addr, data_wdata};
      end else if (inst_req) begin
        m_busy = 1'b1; m_acc = 1'b0;
        m_t = '{1'b0, 1'b0, 2'd2, inst_addr, 32'd0};
      end
    end else if (!m_acc) begin
      if (bus_addr_ok) m_acc = 1'b1;
    end else if (bus_data_ok) begin
      if (m_t.side) m_dr = bus_rdata;
      else m_ir = bus_rdata;
      m_busy = 1'b0;
    end
  end

  dreq_t       blog[$];
  int          n_iaok = 0, n_daok = 0, n_idok = 0, n_ddok = 0, n_breq = 0;
  logic [31:0] last_ird = '0, last_drd = '0;
  logic        ist_dok = 1'b1;
  logic        e_breq, e_iaok, e_daok, e_idok, e_ddok, e_ist, e_dst;

  always @(negedge clk) begin
    e_breq = m_busy && !m_acc;
    e_iaok = e_breq && !m_t.side && bus_addr_ok;
    e_daok = e_breq && m_t.side && bus_addr_ok;
    e_idok = m_busy && m_acc && !m_t.side && bus_data_ok;
    e_ddok = m_busy && m_acc && m_t.side && bus_data_ok;
    e_ist  = (inst_req || (m_busy && !m_t.side)) && !e_idok;
    e_dst  = (data_req || (m_busy && m_t.side)) && !e_ddok;
    chk("bus_req", bus_req, e_breq);
    chk("bus_wr", bus_wr, m_t.wr);
    chk("bus_size", bus_size, m_t.size);
    chk("bus_addr", bus_addr, m_t.addr);
    if (m_t.side) chk("bus_wdata", bus_wdata, m_t.wdata);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_data_ok", inst_data_ok, e_idok);
    chk("data_data_ok", data_data_ok, e_ddok);
    chk("inst_rdata", inst_rdata, e_idok ? bus_rdata : m_ir);
    chk("data_rdata", data_rdata, e_ddok ? bus_rdata : m_dr);
    chk("inst_stall", inst_stall, e_ist);
    chk("data_stall", data_stall, e_dst);
    if (bus_req) n_breq++;
    if (bus_req && bus_addr_ok)
      blog.push_back('{bus_wr, bus_size, bus_addr, bus_wdata});
    if (inst_addr_ok) n_iaok++;
    if (data_addr_ok) n_daok++;
    if (inst_data_ok) begin
      n_idok++; last_ird = inst_rdata; ist_dok = inst_stall;
    end
    if (data_data_ok) begin
      n_ddok++; last_drd = data_rdata;
    end
  end

  task automatic wait_done(input string nm, input int ti, input int td,
                           input int budget);
    int k = 0;
    while (!(n_idok >= ti && n_ddok >= td) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, (n_idok >= ti && n_ddok >= td), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b, ia, da, ib, db, br;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_size", bus_size, 2'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_inst_stall", inst_stall, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;

    // Single fetch, zero wait states.
    @(negedge clk);
    b = blog.size(); br = n_breq;
    rq.push_back(32'h3C1D0001);
    iq.push_back(32'hBFC00000);
    wait_done("t1_done", 1, 0, 40);
    chk("t1_addr", blog[b].addr, 32'hBFC00000);
    chk("t1_wr", blog[b].wr, 1'b0);
    chk("t1_size", blog[b].size, 2'd2);
    chk("t1_rdata", last_ird, 32'h3C1D0001);
    chk("t1_stall_at_ok", ist_dok, 1'b0);
    chk("t1_breq_cycles", n_breq - br, 1);

    // Simultaneous requests: data first.
    b = blog.size();
    rq.push_back(32'h0); rq.push_back(32'h24080005);
    dq.push_back('{1'b1, 2'd2, 32'h80000010, 32'hDEADBEEF});
    iq.push_back(32'h00000100);
    wait_done("t2_done", 2, 1, 60);
    chk("t2_first_wr", blog[b].wr, 1'b1);
    chk("t2_first_wdata", blog[b].wdata, 32'hDEADBEEF);
    chk("t2_first_addr", blog[b].addr, 32'h80000010);
    chk("t2_second_addr", blog[b+1].addr, 32'h00000100);
    chk("t2_inst_rdata", last_ird, 32'h24080005);

    // Wait states on both phases.
    a_dly = 4; d_dly = 3;
    ia = n_iaok; da = n_daok; ib = n_idok; db = n_ddok; br = n_breq;
    rq.push_back(32'hCAFE0001);
    iq.push_back(32'h00000200);
    wait_done("t3_done", ib + 1, db, 60);
    chk("t3_iaok_n", n_iaok - ia, 1);
    chk("t3_daok_n", n_daok - da, 0);
    chk("t3_idok_n", n_idok - ib, 1);
    chk("t3_ddok_n", n_ddok - db, 0);
    chk("t3_breq_cycles", n_breq - br, 5);
    chk("t3_rdata", last_ird, 32'hCAFE0001);

    // Byte load.
    a_dly = 0; d_dly = 0;
    b = blog.size();
    rq.push_back(32'h11223344);
    dq.push_back('{1'b0, 2'd0, 32'h80000003, 32'd0});
    wait_done("t4_done", n_idok, n_ddok + 1, 40);
    chk("t4_size", blog[b].size, 2'd0);
    chk("t4_addr", blog[b].addr, 32'h80000003);
    chk("t4_rdata", last_drd, 32'h11223344);

    // Spurious data_ok in IDLE, then in ADDR with and without addr_ok.
    ib = n_idok; db = n_ddok; br = n_breq;
    @(posedge clk); #2; spur = 1'b1;
    @(posedge clk); #2; spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_idle_dok", (n_idok - ib) + (n_ddok - db), 0);
    chk("t5_idle_breq", n_breq - br, 0);
    for (int d = 1; d <= 2; d++) begin
      int k;
      a_dly = d; d_dly = 2;
      ib = n_idok; br = n_breq;
      iq.push_back(32'h00000300 + d);
      k = 0;
      while (!bus_req && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("t5_saw_breq", bus_req, 1'b1);
      @(posedge clk); #2; spur = 1'b1;
      @(posedge clk); #2; spur = 1'b0;
      wait_done("t5_done", ib + 1, n_ddok, 40);
      chk("t5_idok_n", n_idok - ib, 1);
      chk("t5_breq_cycles", n_breq - br, d + 1);
    end

    // Reset while waiting for data; pending fetch re-arbitrated after.
    begin
      int k;
      a_dly = 0; d_dly = 6;
      da = n_daok;
      dq.push_back('{1'b0, 2'd2, 32'h80000020, 32'd0});
      iq.push_back(32'h00000400);
      k = 0;
      while (n_daok == da && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("t6_data_addr_ok", n_daok - da, 1);
      @(posedge clk); #2; rst = 1'b0;
      d_dly = 0;
      @(negedge clk);
      chk("t6_rst_breq", bus_req, 1'b0);
      chk("t6_rst_addr", bus_addr, 32'd0);
      chk("t6_rst_ddok", data_data_ok, 1'b0);
      chk("t6_rst_istall", inst_stall, 1'b1);
      chk("t6_rst_drdata", data_rdata, 32'd0);
      @(posedge clk); #2; rst = 1'b1;
      @(negedge clk);
      chk("t6_idle_breq", bus_req, 1'b0);
      @(negedge clk);
      chk("t6_regrant_breq", bus_req, 1'b1);
      chk("t6_regrant_addr", bus_addr, 32'h00000400);
      wait_done("t6_done", n_idok + 1, n_ddok, 40);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Arbitrates the pipeline's instruction-fetch port and data-memory port onto one shared SRAM-like memory bus, with at most one transaction outstanding at a time. It sits between the datapath/controller and the bus bridge. It generates the `inst_stall` and `data_stall` signals that the hazard unit combines into `longest_stall`.

## Interface
Parameters:
- `ADDR_W`, default 32: address width of all ports.
- `DATA_W`, default 32: data width of all ports.
- `DATA_FIRST`, default 1: 1 means data wins a simultaneous request; 0 means inst wins.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_req`  in  1  fetch request; held stable until `inst_addr_ok`.
- `inst_addr`  in  ADDR_W  fetch address.
- `inst_addr_ok`  out  1  fetch address accepted.
- `inst_data_ok`  out  1  fetch data valid.
- `inst_rdata`  out  DATA_W  fetched word.
- `data_req`  in  1  data request; held stable until `data_addr_ok`.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  ADDR_W  data address.
- `data_wdata`  in  DATA_W  store data.
- `data_addr_ok`  out  1  data address accepted.
- `data_data_ok`  out  1  load data valid, or store complete.
- `data_rdata`  out  DATA_W  load data.
- `bus_req`  out  1  bus request.
- `bus_wr`  out  1  bus write.
- `bus_size`  out  2  bus transfer size.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  DATA_W  bus write data.
- `bus_addr_ok`  in  1  bus accepted the address phase.
- `bus_data_ok`  in  1  bus completed the data phase.
- `bus_rdata`  in  DATA_W  bus read data.
- `inst_stall`  out  1  fetch side must hold.
- `data_stall`  out  1  data side must hold.

## Operation
- **FSM states:** IDLE, ADDR, DATA. There is also a 1-bit `grant` register: 0 = inst, 1 = data.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If one request is high, that requester wins.
  - If both are high, `DATA_FIRST` selects the winner.
  - On a win, register `grant`, `bus_wr`, `bus_size`, `bus_addr` and `bus_wdata`, then go to ADDR.
  - An inst grant forces `bus_wr`=0 and `bus_size`=2.
- **ADDR:**
  - `bus_req`=1.
  - On `bus_addr_ok`, pulse the granted requester's `*_addr_ok` in the same cycle (combinational) and go to DATA.
- **DATA:**
  - `bus_req`=0.
  - On `bus_data_ok`, pulse the granted requester's `*_data_ok` and drive its `*_rdata` = `bus_rdata` in the same cycle, then go to IDLE.
- **Losing requester:** keeps its request high and is served in the next IDLE. With `DATA_FIRST`=1, a continuous data stream can starve fetch. This is accepted, because data requests come from the older instruction.
- **Unselected responses:** `*_addr_ok` and `*_data_ok` of the non-granted side are always 0. Its `*_rdata` holds its last value.
- **Stall rule:**
  - `inst_stall` = (`inst_req` | inst transaction in flight) & ~`inst_data_ok`.
  - `data_stall` is defined the same way for the data side.
  - Both are combinational from state and inputs.
- **`bus_addr_ok` outside ADDR:** ignored.
- **`bus_data_ok` outside DATA:** ignored. It produces no pulse and no state change.
- **Requester drops `req` before `addr_ok`:** this is a protocol violation. The registered transaction still completes on the bus.

## Timing
- **Reset (rst=0, asynchronous):**
  - State = IDLE, `grant`=0.
  - All `bus_*` outputs = 0.
  - All `*_addr_ok` and `*_data_ok` = 0.
  - `*_rdata` = 0.
  - Stall outputs follow the rule above, so they equal the raw `*_req` inputs.
  - Reset mid-transaction abandons the transaction without completing it.
- **Minimum transaction timeline:**
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `bus_req`=1.
  - `bus_addr_ok` in cycle 1 gives `*_addr_ok` in cycle 1.
  - `bus_data_ok` in cycle 2 gives `*_data_ok` in cycle 2.
  - Next arbitration happens in cycle 3.
- **Throughput:** at least 3 cycles per transaction. There is no overlap of transactions.
- **Bus latency:** `bus_*` outputs stay stable from the cycle after the grant until `bus_addr_ok`, for any number of wait cycles.
- **Simultaneous events:** `bus_addr_ok` and `bus_data_ok` high in the same ADDR cycle → only `addr_ok` is taken; `data_ok` is expected in DATA.

## Test plan
- **Single fetch.** Stimulus: `inst_req`=1, `inst_addr`=0xBFC00000; bus gives `addr_ok` on the 1st cycle of `bus_req` and `data_ok` one cycle later with `rdata`=0x3C1D0001. Required: `bus_addr`=0xBFC00000, `bus_wr`=0, `bus_size`=2; `inst_data_ok` pulses with `inst_rdata`=0x3C1D0001; `inst_stall` drops in that same cycle.
- **Simultaneous requests, `DATA_FIRST`=1.** Stimulus: inst address 0x100 and data store 0x80000010 / 0xDEADBEEF / size 2 raised together. Required: data is served first (`bus_wr`=1, `bus_wdata`=0xDEADBEEF); inst is served in the next IDLE; `inst_stall` stays high throughout.
- **Bus wait states.** Stimulus: `bus_addr_ok` delayed 4 cycles, `bus_data_ok` delayed 3 cycles. Required: `bus_*` outputs are constant while waiting; exactly one `addr_ok` pulse and one `data_ok` pulse, each to the granted side only.
- **Byte load.** Stimulus: `data_size`=0, `data_addr`=0x80000003. Required: `bus_size`=0, `bus_addr`=0x80000003, `data_rdata`=`bus_rdata` unchanged.
- **Spurious bus pulse.** Stimulus: `bus_data_ok` pulsed while in IDLE and again while in ADDR. Required: no `*_data_ok` output and no state change.
- **Reset in DATA.** Stimulus: `rst`=0 for 1 cycle while waiting for data. Required: immediate return to IDLE; all bus and ok outputs 0; a pending `inst_req` is re-arbitrated in the first cycle after reset is released.
